sum_tx: RTL

SUM_TX -- requirements
Module: sum_tx

---
 rtl/sum_tx_pkg.sv | 38 +++
 rtl/sum_tx_baud.sv | 31 +++
 rtl/sum_tx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sum_tx_pkg.sv
// Shared types and constants for the sum_tx serial adder transmitter.
// Build option: define SUM_TX_PARITY_EN to add an even-parity bit.
package sum_tx_pkg;

    localparam int DATA_BITS        = 8;
    localparam int FRAME_BITS_NOPAR = 10;
    localparam int FRAME_BITS_PAR   = 11;

`ifdef SUM_TX_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PAR;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    localparam int FRAME_BITS = FRAME_BITS_NOPAR;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    // 9-bit sum: bit 8 is the carry-out
    function automatic logic [8:0] add9(
        input logic [7:0] x,
        input logic [7:0] y
    );
        return {1'b0, x} + {1'b0, y};
    endfunction

endpackage

// File: rtl/sum_tx_baud.sv
// Bit-period counter for sum_tx: counts 0..CLKS_PER_BIT-1 while enabled
// and pulses bit_done on the last cycle of every bit.
module sum_tx_baud #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_done
);

    localparam int CW =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Free-run while a frame is active, held at zero otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_done = en && (cnt == LAST);

endmodule

// File: rtl/sum_tx.sv
// Adds two bytes and transmits the sum as a UART-style frame.
// Build option: SUM_TX_PARITY_EN inserts an even-parity bit before STOP.
module sum_tx
    import sum_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       txd,
    output logic       busy,
    output logic       overflow
);

    state_t     state;
    state_t     state_next;
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic       ready_q;
    logic       bit_done;
    logic       accept;
    logic       active;
    logic [8:0] sum9;
`ifdef SUM_TX_PARITY_EN
    logic       par_q;
`endif

    assign active = (state != IDLE);
    assign accept = in_valid && ready_q && (state == IDLE);
    assign sum9   = add9(a, b);

    sum_tx_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .en      (active),
        .bit_done(bit_done)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and line/handshake outputs
    always_comb begin
        state_next = state;
        txd        = 1'b1;
        busy       = 1'b1;
        in_ready   = 1'b0;
        unique case (state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = ready_q;
                if (accept) state_next = START;
            end
            START: begin
                txd = 1'b0;
                if (bit_done) state_next = DATA;
            end
            DATA: begin
                txd = shreg[0];
                if (bit_done && bit_idx == 3'd7) begin
`ifdef SUM_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef SUM_TX_PARITY_EN
            PARITY: begin
                txd = par_q;
                if (bit_done) state_next = STOP;
            end
`endif
            STOP: begin
                txd = 1'b1;
                if (bit_done) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, data shifting and post-reset ready qualifier
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q  <= 1'b0;
            shreg    <= '0;
            bit_idx  <= '0;
            overflow <= 1'b0;
`ifdef SUM_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b1;
            if (accept) begin
                shreg    <= sum9[7:0];
                overflow <= sum9[8];
                bit_idx  <= '0;
`ifdef SUM_TX_PARITY_EN
                par_q    <= ^sum9[7:0];
`endif
            end else if (state == DATA && bit_done) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule
